counter_updown_modulus_param: RTL
=================================

Name: counter_updown_modulus_param

Overview:
- Synchronous modulo-N up/down counter, parametrised in width and modulus.
- Adds count enable, direction control, synchronous clear and parallel load with range clamping.
- Adds a terminal-count output for cascading stages.
- Used as a timebase / cascaded prescaler in the counters library.

Parameters:
- WIDTH, 8, counter and data width in bits; legal 2..32.
- MODULUS, 47, count sequence is 0..MODULUS-1; legal 2..2**WIDTH.
- LOAD_CLAMP, 1, 1: load value >= MODULUS is loaded as MODULUS-1; 0: such a load is loaded as 0.

Ports:
- clk  input  1  rising-edge clock.
- reset_ah_in  input  1  asynchronous, active-high reset.
- clear_in  input  1  synchronous clear to 0.
- load_in  input  1  synchronous parallel load of d_in.
- d_in  input  WIDTH  load data.
- en_in  input  1  count enable.
- up_in  input  1  direction: 1 = increment, 0 = decrement.
- q_out  output  WIDTH  registered count value.
- tc_out  output  1  terminal count, combinational.
- wrap_out  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Interface: one clock, clk; reset_ah_in is asynchronous and active-high.
- Reset state:
  - reset_ah_in high forces q_out=0 and wrap_out=0 immediately, independent of clk.
  - Outputs are held while reset is asserted.
  - The first count happens on the first rising clk edge after deassertion.
- Priority at each rising edge, highest first: clear_in > load_in > en_in count > hold.
- Clear: q_out <= 0, wrap_out <= 0. This applies regardless of load_in and en_in.
- Load:
  - If d_in < MODULUS: q_out <= d_in.
  - Otherwise: q_out <= MODULUS-1 when LOAD_CLAMP=1, or 0 when LOAD_CLAMP=0.
  - Load ignores en_in. wrap_out <= 0.
- Count up (en_in=1, up_in=1):
  - q_out==MODULUS-1: q_out <= 0, wrap_out <= 1.
  - Otherwise: q_out <= q_out+1, wrap_out <= 0.
- Count down (en_in=1, up_in=0):
  - q_out==0: q_out <= MODULUS-1, wrap_out <= 1.
  - Otherwise: q_out <= q_out-1, wrap_out <= 0.
- Hold (en_in=0, no clear, no load): q_out unchanged, wrap_out <= 0.
- tc_out:
  - Equals en_in & ~clear_in & ~load_in & ((up_in & q_out==MODULUS-1) | (~up_in & q_out==0)).
  - It is high exactly in the cycle whose edge will wrap.
  - Intended to drive the en_in of the next stage.
- Invariant: q_out < MODULUS at all times. No path may produce an out-of-range value.
- Arithmetic:
  - Increment and decrement are WIDTH bits wide.
  - Comparisons use MODULUS-1 sized to WIDTH bits.
  - When MODULUS==2**WIDTH, wrap coincides with natural binary overflow.
- Direction change takes effect on the next enabled edge; there is no pipeline delay.
- Latency: one clk edge from a control input to q_out; zero for tc_out.
- Elaboration: MODULUS or WIDTH outside the legal range is a fatal error.

Test Plan:
- Reset/release: assert reset_ah_in mid-count at q_out=23 with no clk edge -> q_out=0 immediately. Release, en_in=1, up_in=1, 3 edges -> q_out=3.
- Up wrap: load 45, en_in=1, up_in=1 -> q_out 45, 46, 0, 1. tc_out=1 only while q_out=46. wrap_out=1 only in the cycle q_out=0.
- Down wrap: load 1, up_in=0 -> q_out 1, 0, 46, 45. tc_out=1 while q_out=0. wrap_out pulses with q_out=46.
- Load clamp: d_in=200, load_in=1 -> q_out=46 (LOAD_CLAMP=1). Rebuild with LOAD_CLAMP=0 -> q_out=0. d_in=10 -> q_out=10 in both builds.
- Priority: clear_in=1, load_in=1, d_in=30, en_in=1 -> q_out=0. Then load_in=1, en_in=1, d_in=30 -> q_out=30, not 31. tc_out=0 throughout while clear_in or load_in is high.
- Cascade: two instances (MODULUS=10, then MODULUS=6), first tc_out driving second en_in, en_in=1 for 60 edges from reset -> both q_out=0. Second stage wrap_out pulses exactly once, at edge 60.

Source files
------------

// File: rtl/counter_updown_modulus_param.sv
// Modulo-MODULUS up/down counter with clear, clamped parallel load, a
// combinational terminal count for cascading and a registered wrap pulse.
module counter_updown_modulus_param #(
    parameter int unsigned      WIDTH      = 8,
    parameter longint unsigned  MODULUS    = 47,
    parameter int unsigned      LOAD_CLAMP = 1
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             clear_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             en_in,
    input  logic             up_in,
    output logic [WIDTH-1:0] q_out,
    output logic             tc_out,
    output logic             wrap_out
);

    if ((WIDTH < 32'd2) || (WIDTH > 32'd32) || (MODULUS < 64'd2) ||
        (MODULUS > (64'd1 << WIDTH))) begin : g_bad_params
        $fatal(1, "counter_updown_modulus_param: WIDTH or MODULUS out of range");
    end

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_C  = '0;
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(64'd1);
    // Out-of-range loads collapse to either end of the count sequence.
    localparam logic [WIDTH-1:0] CLAMP_C = (LOAD_CLAMP != 32'd0) ? MAX_C : ZERO_C;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max_s;
    logic             at_zero_s;
    logic             load_ok_s;

    assign at_max_s  = (q_q == MAX_C);
    assign at_zero_s = (q_q == ZERO_C);
    assign load_ok_s = (64'(d_in) < MODULUS);

    // Next-state selection in priority order: clear, load, count, hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clear_in) begin
            q_d    = ZERO_C;
            wrap_d = 1'b0;
        end else if (load_in) begin
            if (load_ok_s) begin
                q_d = d_in;
            end else begin
                q_d = CLAMP_C;
            end
            wrap_d = 1'b0;
        end else if (en_in) begin
            if (up_in) begin
                if (at_max_s) begin
                    q_d    = ZERO_C;
                    wrap_d = 1'b1;
                end else begin
                    q_d    = q_q + ONE_C;
                    wrap_d = 1'b0;
                end
            end else begin
                if (at_zero_s) begin
                    q_d    = MAX_C;
                    wrap_d = 1'b1;
                end else begin
                    q_d    = q_q - ONE_C;
                    wrap_d = 1'b0;
                end
            end
        end else begin
            q_d    = q_q;
            wrap_d = 1'b0;
        end
    end

    // Count and wrap registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            q_q    <= ZERO_C;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // High only when the coming edge is an enabled count that wraps.
    assign tc_out   = en_in & ~clear_in & ~load_in &
                      ((up_in & at_max_s) | (~up_in & at_zero_s));
    assign q_out    = q_q;
    assign wrap_out = wrap_q;

endmodule
